// File: rtl/funct_generator_wave_engine.sv
// Waveform sample engine: turns the register-file settings into a paced
// stream of square/sawtooth/triangle samples pushed into the generator FIFO.
module funct_generator_wave_engine #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    CNT_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic [1:0]            sel_i,
   input  logic [DATA_WIDTH-1:0] amp_i,
   input  logic [CNT_WIDTH-1:0]  div_i,
   input  logic [CNT_WIDTH-1:0]  half_i,
   input  logic                  full_i,
   output logic                  wr_en_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  busy_o,
   output logic                  stall_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  ONE_C = CNT_WIDTH'(1);

   localparam logic [1:0] SEL_SQ  = 2'b00;
   localparam logic [1:0] SEL_SAW = 2'b01;
   localparam logic [1:0] SEL_TRI = 2'b10;

   state_t                state_q;
   state_t                state_d;

   logic [1:0]            sel_q;
   logic [DATA_WIDTH-1:0] amp_q;
   logic [CNT_WIDTH-1:0]  div_q;
   logic [CNT_WIDTH-1:0]  half_q;
   logic [CNT_WIDTH-1:0]  div_cnt_q;
   logic [CNT_WIDTH-1:0]  div_cnt_d;

   logic [DATA_WIDTH-1:0] val_q;
   logic                  down_q;
   logic [CNT_WIDTH-1:0]  sq_cnt_q;
   logic                  sq_high_q;

   logic [DATA_WIDTH-1:0] val_adv;
   logic                  down_adv;
   logic [CNT_WIDTH-1:0]  sq_cnt_adv;
   logic                  sq_high_adv;
   logic [CNT_WIDTH-1:0]  half_eff;

   logic [DATA_WIDTH-1:0] sample;
   logic [DATA_WIDTH-1:0] data_d;
   logic                  wr_en_d;
   logic                  load;
   logic                  push;

   // current sample of the latched waveform, before it is advanced
   always_comb begin
      sample = '0;
      case (sel_q)
         SEL_SQ:  sample = sq_high_q ? amp_q : '0;
         SEL_SAW: sample = val_q;
         SEL_TRI: sample = val_q;
         default: sample = '0;
      endcase
   end

   // wave state after one sample has been emitted
   always_comb begin
      val_adv     = val_q;
      down_adv    = down_q;
      sq_cnt_adv  = sq_cnt_q;
      sq_high_adv = sq_high_q;
      half_eff    = (half_q == '0) ? ONE_C : half_q;
      case (sel_q)
         SEL_SQ: begin
            if (sq_cnt_q >= half_eff - ONE_C) begin
               sq_cnt_adv  = '0;
               sq_high_adv = ~sq_high_q;
            end else begin
               sq_cnt_adv = sq_cnt_q + ONE_C;
            end
         end
         SEL_SAW: begin
            val_adv = (val_q >= amp_q) ? '0 : val_q + ONE_D;
         end
         SEL_TRI: begin
            if (amp_q == '0) begin
               val_adv  = '0;
               down_adv = 1'b0;
            end else if (!down_q) begin
               if (val_q >= amp_q) begin
                  val_adv  = val_q - ONE_D;
                  down_adv = 1'b1;
               end else begin
                  val_adv = val_q + ONE_D;
               end
            end else begin
               if (val_q == '0) begin
                  val_adv  = ONE_D;
                  down_adv = 1'b0;
               end else begin
                  val_adv = val_q - ONE_D;
               end
            end
         end
         default: ;
      endcase
   end

   // next-state, pacing counter and push decision
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      wr_en_d   = 1'b0;
      data_d    = data_o;
      load      = 1'b0;
      push      = 1'b0;
      unique case (state_q)
         IDLE: begin
            div_cnt_d = '0;
            if (en_i) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (div_cnt_q == div_q) begin
               if (!full_i) begin
                  push = 1'b1;
               end else begin
                  state_d = HOLD;
               end
            end else begin
               div_cnt_d = div_cnt_q + ONE_C;
            end
         end
         HOLD: begin
            if (!en_i) begin
               state_d = IDLE;
            end else if (!full_i) begin
               push    = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
      if (push) begin
         wr_en_d   = 1'b1;
         data_d    = sample;
         div_cnt_d = '0;
      end
   end

   // state register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         wr_en_o   <= 1'b0;
         data_o    <= RESET_VAL;
         busy_o    <= 1'b0;
         stall_o   <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         wr_en_o   <= wr_en_d;
         data_o    <= data_d;
         busy_o    <= (state_d != IDLE);
         stall_o   <= (state_d == HOLD);
      end
   end

   // settings latch on enable, wave state advances once per push
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q     <= '0;
         amp_q     <= '0;
         div_q     <= '0;
         half_q    <= '0;
         val_q     <= '0;
         down_q    <= 1'b0;
         sq_cnt_q  <= '0;
         sq_high_q <= 1'b1;
      end else if (load) begin
         sel_q     <= sel_i;
         amp_q     <= amp_i;
         div_q     <= div_i;
         half_q    <= half_i;
         val_q     <= '0;
         down_q    <= 1'b0;
         sq_cnt_q  <= '0;
         sq_high_q <= 1'b1;
      end else if (push) begin
         val_q     <= val_adv;
         down_q    <= down_adv;
         sq_cnt_q  <= sq_cnt_adv;
         sq_high_q <= sq_high_adv;
      end
   end

endmodule
